seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 6, which sets the operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand/op bundle present.
REQ-005 in_ready  output  1  block can accept a bundle this cycle.
REQ-006 A  input  WIDTH  operand A (two's complement).
REQ-007 B  input  WIDTH  operand B (two's complement).
REQ-008 op  input  3  operation select.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out  output  WIDTH  result.
REQ-012 flags  output  4  {carry, overflow, negative, zero}, MSB first.

Function
REQ-013 A bundle SHALL be accepted on a rising edge where in_valid && in_ready; A, B and op SHALL be captured at that edge, and later input changes SHALL have no effect on that operation.
REQ-014 The op encoding SHALL be: 0 ADD; 1 SUB (A-B); 2 AND; 3 OR; 4 XOR; 5 MUL (unsigned, shift-add); 6 SLT (signed A<B gives 1, else 0); 7 PASS (A).
REQ-015 Results SHALL be the low WIDTH bits of the exact result; arithmetic SHALL wrap modulo 2^WIDTH.
REQ-016 Carry SHALL be: the ADD carry-out; the SUB borrow (1 iff A<B unsigned); for MUL, 1 iff the upper WIDTH bits of the 2*WIDTH product are nonzero; 0 for all other ops.
REQ-017 Overflow SHALL be the signed overflow for ADD and SUB, and 0 for all other ops.
REQ-018 Negative SHALL be out[WIDTH-1] and zero SHALL be (out==0), for every op.
REQ-019 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-020 From IDLE, acceptance of a non-MUL op SHALL go to DONE, with the result registered at the acceptance edge (latency 1: out_valid is high on the next cycle).
REQ-021 From IDLE, acceptance of MUL SHALL go to BUSY; BUSY SHALL run one multiplier bit per cycle for exactly WIDTH cycles, then go to DONE (latency WIDTH+1 from acceptance to out_valid).
REQ-022 From DONE, out_valid=1 SHALL hold and out/flags SHALL stay stable until out_ready=1; on that edge the block SHALL return to IDLE, unless a new bundle is accepted on the same edge.
REQ-023 in_ready SHALL be (state==IDLE) || (state==DONE && out_ready), and SHALL be combinational from state and out_ready only.
REQ-024 When out_ready and in_valid are both high in DONE, the result SHALL be consumed and the new bundle accepted on the same edge, allowing back-to-back single-cycle ops at full throughput.
REQ-025 While in BUSY, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-026 out_valid SHALL be 1 only in DONE.

Reset
REQ-027 Asserting rst SHALL immediately force: state=IDLE, out_valid=0, out=0, flags=0000, and the multiplier counter and partial product to 0.
REQ-028 While rst=1, in_ready SHALL be 0; after deassertion, in_ready SHALL be 1 in IDLE.
REQ-029 Reset during BUSY or DONE SHALL abandon the operation, with no result ever presented.

Verification (WIDTH=6)
REQ-030 ADD with A=111011 (-5), B=010100 (20), out_ready=1 -> one cycle later out=001111, flags=1000, out_valid pulses for 1 cycle.
REQ-031 SUB with A=5, B=10 -> out=111011, flags=1010 (borrow, negative).
REQ-032 MUL with A=3, B=2 -> in_ready=0 for 6 cycles, out_valid on cycle 7 after acceptance, out=000110, flags=0000. MUL with A=63, B=63 -> out=000001, carry=1.
REQ-033 SLT with A=-3, B=-10 -> out=0, zero=1; out_ready held low 5 cycles -> out/flags stable and in_ready=0 throughout.
REQ-034 Back-to-back ADD/XOR/OR with in_valid=out_ready=1 continuously -> one result per cycle, in order, with no bubbles.
REQ-035 rst asserted on cycle 3 of a MUL -> out_valid=0 immediately, in_ready=1 after release, and a following ADD 3+2 -> out=000101.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish in one clock; MUL is a shift-add loop, one multiplier bit per clock.
module seq_alu #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_SLT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     out_reg;
    logic [3:0]           flags_reg;

    logic                 accept;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic [3:0]           alu_flags;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 mul_hi_nz;

    assign accept = in_valid && in_ready;

    // Single-cycle datapath
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} - {1'b0, B};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_PASS: alu_res = A;
            default: alu_res = '0;
        endcase
        alu_flags = {alu_c, alu_v, alu_res[WIDTH-1], (alu_res == '0)};
    end

    // Partial product for the current multiplier bit
    generate
        for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign acc_sum   = acc_reg + addend;
    assign mul_hi_nz = |acc_sum[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = (op == OP_MUL) ? BUSY : DONE;
            BUSY: if (cnt_reg == LAST) state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    if (in_valid) state_next = (op == OP_MUL) ? BUSY : DONE;
                    else          state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset also gates in_ready so nothing is offered while it is held
    always_comb begin
        in_ready  = !rst && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            out_reg    <= '0;
            flags_reg  <= '0;
        end else if (accept) begin
            if (op == OP_MUL) begin
                mcand_reg  <= {{WIDTH{1'b0}}, A};
                mplier_reg <= B;
                acc_reg    <= '0;
                cnt_reg    <= '0;
            end else begin
                out_reg   <= alu_res;
                flags_reg <= alu_flags;
            end
        end else if (state_reg == BUSY) begin
            acc_reg    <= acc_sum;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CW'(1);
            if (cnt_reg == LAST) begin
                out_reg   <= acc_sum[WIDTH-1:0];
                flags_reg <= {mul_hi_nz, 1'b0, acc_sum[WIDTH-1], (acc_sum[WIDTH-1:0] == '0)};
            end
        end
    end

    assign out   = out_reg;
    assign flags = flags_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=6; expected values are hand-computed.
module tb_seq_alu;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [3:0]   flags;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle op with out_ready high: result next cycle, valid for one cycle only
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] o, input logic [W-1:0] eout, input logic [3:0] efl);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        A = a; B = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; A = 6'(~a); B = 6'(~b);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_out"}, 32'(out), 32'(eout));
        chk({tag, "_flg"}, 32'(flags), 32'(efl));
        $display("op %s A=%b B=%b -> out=%b flags=%b", tag, a, b, out, flags);
        step();
        chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    // MUL: six busy cycles with in_ready low, result on the seventh
    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eout, input logic [3:0] efl);
        A = a; B = b; op = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
        step();
        A = 6'(~a); B = 6'(~b); op = 3'd0;
        for (int i = 0; i < W; i++) begin
            chk({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
            chk({tag, "_busy_vld"}, 32'(out_valid), 32'd0);
            if (i == W - 1) in_valid = 1'b0;
            step();
        end
        in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_out"}, 32'(out), 32'(eout));
        chk({tag, "_flg"}, 32'(flags), 32'(efl));
        $display("op %s A=%b B=%b -> out=%b flags=%b", tag, a, b, out, flags);
        step();
        chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; op = '0;
        #1;
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_flg", 32'(flags), 32'd0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 32'(in_ready), 32'd1);
        step();

        run_op("add_neg5_20", 6'b111011, 6'b010100, 3'd0, 6'b001111, 4'b1000);
        run_op("sub_5_10",    6'd5,      6'd10,     3'd1, 6'b111011, 4'b1010);
        run_op("add_ovf",     6'd31,     6'd1,      3'd0, 6'b100000, 4'b0110);
        run_op("sub_eq",      6'd7,      6'd7,      3'd1, 6'b000000, 4'b0001);
        run_op("and",         6'b101100, 6'b100110, 3'd2, 6'b100100, 4'b0010);
        run_op("pass_zero",   6'd0,      6'd17,     3'd7, 6'b000000, 4'b0001);
        run_op("slt_true",    6'b111101, 6'd2,      3'd6, 6'b000001, 4'b0000);
        run_mul("mul_3_2",    6'd3,  6'd2,  6'b000110, 4'b0000);
        run_mul("mul_63_63",  6'd63, 6'd63, 6'b000001, 4'b1000);

        // SLT -3 < -10 is false; consumer stalls for five cycles
        A = 6'b111101; B = 6'b110110; op = 3'd6; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; A = 6'd0; B = 6'd1;
        for (int i = 0; i < 5; i++) begin
            chk("slt_stall_vld", 32'(out_valid), 32'd1);
            chk("slt_stall_out", 32'(out), 32'd0);
            chk("slt_stall_flg", 32'(flags), 32'b0001);
            chk("slt_stall_rdy", 32'(in_ready), 32'd0);
            step();
        end
        $display("op slt_stall -> out=%b flags=%b", out, flags);
        out_ready = 1'b1;
        #1;
        chk("slt_release_rdy", 32'(in_ready), 32'd1);
        step();
        chk("slt_release_vld", 32'(out_valid), 32'd0);

        // Back-to-back ADD, XOR, OR at full throughput
        A = 6'd1; B = 6'd2; op = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        A = 6'd5; B = 6'd3; op = 3'd4;
        chk("b2b_add_vld", 32'(out_valid), 32'd1);
        chk("b2b_add_out", 32'(out), 32'd3);
        chk("b2b_add_rdy", 32'(in_ready), 32'd1);
        step();
        A = 6'd40; B = 6'd3; op = 3'd3;
        chk("b2b_xor_vld", 32'(out_valid), 32'd1);
        chk("b2b_xor_out", 32'(out), 32'd6);
        step();
        in_valid = 1'b0;
        chk("b2b_or_vld", 32'(out_valid), 32'd1);
        chk("b2b_or_out", 32'(out), 32'd43);
        chk("b2b_or_flg", 32'(flags), 32'b0010);
        $display("op b2b add/xor/or last out=%b flags=%b", out, flags);
        step();
        chk("b2b_end_vld", 32'(out_valid), 32'd0);

        // Reset on the third cycle of a MUL abandons it
        A = 6'd7; B = 6'd9; op = 3'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        chk("mrst_vld", 32'(out_valid), 32'd0);
        chk("mrst_rdy", 32'(in_ready), 32'd0);
        chk("mrst_out", 32'(out), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mrst_release_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < W + 3; i++) begin
            chk("mrst_no_result", 32'(out_valid), 32'd0);
            step();
        end
        $display("op mul_reset abandoned");
        run_op("add_3_2", 6'd3, 6'd2, 3'd0, 6'b000101, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
